// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: pointers, parity,
// read-pointer synchroniser and registered full/occupancy status.
module async_fifo_wr_ctrl #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 6,
  parameter int ALMOST_FULL_THRESH = 4,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic                  wr_clk_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH:0]   mem_wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow_err,
  output logic [ADDR_WIDTH:0]   wr_occupancy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_THRESH);

  function automatic logic [ADDR_WIDTH:0] bin2gray(
    input logic [ADDR_WIDTH:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_WIDTH:0] gray2bin(
    input logic [ADDR_WIDTH:0] g
  );
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_WIDTH:0] wr_bin;
  logic [ADDR_WIDTH:0] wr_bin_nxt;
  logic [ADDR_WIDTH:0] wr_gray_nxt;
  logic [ADDR_WIDTH:0] rq;
  logic [ADDR_WIDTH:0] rd_bin_sync;
  logic [ADDR_WIDTH:0] occ_nxt;
  logic [ADDR_WIDTH:0] full_cmp;
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;
  logic accept;

  assign accept      = wr_en & wr_clk_en & ~full;
  assign mem_we      = accept;
  assign mem_waddr   = wr_bin[ADDR_WIDTH-1:0];
  assign mem_wdata   = {^wr_data, wr_data};

  assign wr_bin_nxt  = wr_bin + {{ADDR_WIDTH{1'b0}}, accept};
  assign wr_gray_nxt = bin2gray(wr_bin_nxt);
  assign rq          = sync_q[SYNC_STAGES-1];
  assign rd_bin_sync = gray2bin(rq);
  assign occ_nxt     = wr_bin_nxt - rd_bin_sync;
  // full: write pointer one lap ahead, i.e. top two Gray bits inverted
  assign full_cmp    = {~rq[ADDR_WIDTH:ADDR_WIDTH-1],
                        rq[ADDR_WIDTH-2:0]};

  // synchroniser runs on every edge, independent of wr_clk_en
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], rd_gray_ptr};
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin       <= '0;
      wr_gray_ptr  <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      wr_occupancy <= '0;
    end else if (wr_clk_en) begin
      wr_bin       <= wr_bin_nxt;
      wr_gray_ptr  <= wr_gray_nxt;
      full         <= (wr_gray_nxt == full_cmp);
      almost_full  <= (occ_nxt >= AF_LVL);
      wr_occupancy <= occ_nxt;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      overflow_err <= 1'b0;
    else
      overflow_err <= wr_en & wr_clk_en & full;
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl: fill, overflow, read-side
// release, clock-enable gating, wrap-around and mid-burst reset.
module tb_async_fifo_wr_ctrl;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic        wr_en;
  logic        wr_clk_en;
  logic [31:0] wr_data;
  logic [6:0]  rd_gray_ptr;
  logic [6:0]  wr_gray_ptr;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [32:0] mem_wdata;
  logic        full;
  logic        almost_full;
  logic        overflow_err;
  logic [6:0]  wr_occupancy;

  int tests = 0;
  int failed = 0;

  async_fifo_wr_ctrl dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .wr_en        (wr_en),
    .wr_clk_en    (wr_clk_en),
    .wr_data      (wr_data),
    .rd_gray_ptr  (rd_gray_ptr),
    .wr_gray_ptr  (wr_gray_ptr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .full         (full),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .wr_occupancy (wr_occupancy)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [6:0] g7(input int b);
    logic [6:0] v;
    v = 7'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n    = 1'b0;
    wr_en       = 1'b0;
    wr_clk_en   = 1'b1;
    wr_data     = '0;
    rd_gray_ptr = '0;
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  logic [6:0] prev_g;

  initial begin
    // reset state
    do_reset();
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_occ", 64'(wr_occupancy), 64'd0);
    chk("rst_gray", 64'(wr_gray_ptr), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);

    // 64 back-to-back writes with reader idle
    for (int n = 1; n <= 64; n++) begin
      wr_en   = 1'b1;
      wr_data = 32'(n);
      #1;
      chk("fill_we", 64'(mem_we), 64'd1);
      chk("fill_waddr", 64'(mem_waddr), 64'(n - 1));
      tick();
      chk("fill_occ", 64'(wr_occupancy), 64'(n));
      chk("fill_afull", 64'(almost_full), 64'(n >= 60));
      chk("fill_full", 64'(full), 64'(n == 64));
    end
    chk("fill_gray", 64'(wr_gray_ptr), 64'h60);

    // overflow attempts while full
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      #1;
      chk("ovf_we", 64'(mem_we), 64'd0);
      tick();
      chk("ovf_pulse", 64'(overflow_err), 64'd1);
      chk("ovf_gray", 64'(wr_gray_ptr), 64'h60);
      chk("ovf_occ", 64'(wr_occupancy), 64'd64);
    end
    wr_en = 1'b0;
    tick();
    chk("ovf_end", 64'(overflow_err), 64'd0);

    // one read: visible on the third edge
    rd_gray_ptr = g7(1);
    tick();
    chk("rel_full_e1", 64'(full), 64'd1);
    tick();
    chk("rel_full_e2", 64'(full), 64'd1);
    tick();
    chk("rel_full_e3", 64'(full), 64'd0);
    chk("rel_occ_e3", 64'(wr_occupancy), 64'd63);
    chk("rel_afull_e3", 64'(almost_full), 64'd1);

    // clock-enable gating, then parity word
    do_reset();
    wr_data   = 32'h0000_0007;
    wr_en     = 1'b1;
    wr_clk_en = 1'b0;
    #1;
    chk("cen_we", 64'(mem_we), 64'd0);
    tick();
    chk("cen_occ", 64'(wr_occupancy), 64'd0);
    chk("cen_gray", 64'(wr_gray_ptr), 64'd0);
    chk("cen_ovf", 64'(overflow_err), 64'd0);
    wr_clk_en = 1'b1;
    #1;
    chk("cen_we_on", 64'(mem_we), 64'd1);
    chk("par_wdata", 64'(mem_wdata), 64'h1_0000_0007);
    tick();
    chk("cen_occ1", 64'(wr_occupancy), 64'd1);
    chk("cen_waddr1", 64'(mem_waddr), 64'd1);
    wr_en = 1'b0;

    // 130 writes with reader tracking, crossing pointer wrap
    do_reset();
    prev_g = '0;
    for (int e = 1; e <= 130; e++) begin
      wr_en       = 1'b1;
      wr_data     = 32'(e * 3);
      rd_gray_ptr = g7(e - 1);
      #1;
      chk("wrap_waddr", 64'(mem_waddr), 64'((e - 1) % 64));
      tick();
      chk("wrap_gray", 64'(wr_gray_ptr), 64'(g7(e)));
      chk("wrap_step", 64'($countones(wr_gray_ptr ^ prev_g)), 64'd1);
      chk("wrap_full", 64'(full), 64'd0);
      chk("wrap_occ", 64'(wr_occupancy), 64'(e < 3 ? e : 3));
      prev_g = wr_gray_ptr;
    end

    // asynchronous reset in the middle of the burst
    #2;
    wr_rst_n    = 1'b0;
    rd_gray_ptr = '0;
    #1;
    chk("arst_gray", 64'(wr_gray_ptr), 64'd0);
    chk("arst_occ", 64'(wr_occupancy), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_afull", 64'(almost_full), 64'd0);
    chk("arst_ovf", 64'(overflow_err), 64'd0);
    chk("arst_waddr", 64'(mem_waddr), 64'd0);
    tick();
    wr_rst_n = 1'b1;
    #1;
    chk("post_we", 64'(mem_we), 64'd1);
    chk("post_waddr", 64'(mem_waddr), 64'd0);
    tick();
    chk("post_occ", 64'(wr_occupancy), 64'd1);
    chk("post_gray", 64'(wr_gray_ptr), 64'd1);
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
